// File: rtl/mesi_isc_mbus_mem_arb_if.sv
// Main-bus bundle between the four MESI ISC CPUs and the memory arbiter.
//   mbus_cmd_i  : per-CPU command; CPU n is slice [n*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH]
//   mbus_addr_i : per-CPU address; sliced the same way
//   mbus_data_i : per-CPU write data; sliced the same way
//   mbus_ack_o  : one-hot completion pulse, one cycle, to the granted CPU
//   mbus_data_o : read data, valid in the ACK cycle of a RD and held afterwards
//   busy_o      : high while the arbiter is not idle
//   grant_id_o  : CPU currently or most recently granted
// The slave modport is the arbiter side. The master modport is the CPU side.
interface mesi_isc_mbus_mem_arb_if #(
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
);
    logic [4*MBUS_CMD_WIDTH-1:0] mbus_cmd_i;
    logic [4*ADDR_WIDTH-1:0]     mbus_addr_i;
    logic [4*DATA_WIDTH-1:0]     mbus_data_i;
    logic [3:0]                  mbus_ack_o;
    logic [DATA_WIDTH-1:0]       mbus_data_o;
    logic                        busy_o;
    logic [1:0]                  grant_id_o;

    modport slave (
        input  mbus_cmd_i, mbus_addr_i, mbus_data_i,
        output mbus_ack_o, mbus_data_o, busy_o, grant_id_o
    );

    modport master (
        output mbus_cmd_i, mbus_addr_i, mbus_data_i,
        input  mbus_ack_o, mbus_data_o, busy_o, grant_id_o
    );
endinterface

// File: rtl/mesi_isc_mbus_mem_arb.sv
// Round-robin arbiter with a shared main-memory model for the four mbus requesters.
// The arbiter grants one WR or RD at a time. It spends MEM_LAT cycles in ACCESS,
// commits the write or captures the read data, and then pulses the ack of the granted CPU.
//   clk : system clock; all logic runs on the rising edge
//   rst : synchronous, active-high reset; it also clears the memory array
//   bus : slave side of mesi_isc_mbus_mem_arb_if
//         (inputs cmd/addr/data; outputs ack/data/busy/grant_id)
module mesi_isc_mbus_mem_arb #(
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 4,
    parameter int MEM_LAT        = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    mesi_isc_mbus_mem_arb_if.slave   bus
);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR = MBUS_CMD_WIDTH'(1);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD = MBUS_CMD_WIDTH'(2);
    localparam int unsigned MEM_DEPTH = 2 ** MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t                      r_state;
    logic [1:0]                  r_rr_ptr;
    logic [1:0]                  r_grant;
    logic [MBUS_CMD_WIDTH-1:0]   r_cmd;
    logic [MEM_ADDR_WIDTH-1:0]   r_idx;
    logic [DATA_WIDTH-1:0]       r_wdata;
    logic [3:0]                  r_lat;
    logic [3:0]                  r_ack;
    logic [DATA_WIDTH-1:0]       r_data_o;
    logic                        r_busy;
    logic [DATA_WIDTH-1:0]       r_mem [MEM_DEPTH];

    logic [MBUS_CMD_WIDTH-1:0]   w_cmd  [4];
    logic [MEM_ADDR_WIDTH-1:0]   w_idx  [4];
    logic [DATA_WIDTH-1:0]       w_data [4];
    logic [3:0]                  w_req;
    logic                        w_any;
    logic [1:0]                  w_pick;
    logic [1:0]                  w_cand;
    logic                        w_unused_addr;

    // Split each flat bus into per-CPU fields. Address bits above the index are dropped,
    // so addresses wrap around the memory array.
    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            w_cmd[n]  = bus.mbus_cmd_i[n*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
            w_idx[n]  = bus.mbus_addr_i[n*ADDR_WIDTH +: MEM_ADDR_WIDTH];
            w_data[n] = bus.mbus_data_i[n*DATA_WIDTH +: DATA_WIDTH];
            w_req[n]  = (w_cmd[n] == CMD_WR) || (w_cmd[n] == CMD_RD);
        end
    end

    assign w_unused_addr = ^bus.mbus_addr_i;

    // Scan from rr_ptr upward (mod 4). The first requester found wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_rr_ptr;
        w_cand = r_rr_ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            w_cand = r_rr_ptr + 2'(k);
            if (!w_any && w_req[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_cmd    <= '0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_lat    <= '0;
            r_ack    <= '0;
            r_data_o <= '0;
            r_busy   <= 1'b0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_cmd   <= w_cmd[w_pick];
                        r_idx   <= w_idx[w_pick];
                        r_wdata <= w_data[w_pick];
                        r_lat   <= 4'(MEM_LAT - 1);
                        r_busy  <= 1'b1;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_lat == 4'd0) begin
                        // The write commits here, so any later grant sees the new value.
                        if (r_cmd == CMD_RD) begin
                            r_data_o <= r_mem[r_idx];
                        end else if (r_cmd == CMD_WR) begin
                            r_mem[r_idx] <= r_wdata;
                        end
                        r_ack   <= 4'b0001 << r_grant;
                        r_state <= S_ACK;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                S_ACK: begin
                    r_ack    <= '0;
                    r_rr_ptr <= r_grant + 2'd1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mbus_ack_o  = r_ack;
    assign bus.mbus_data_o = r_data_o;
    assign bus.busy_o      = r_busy;
    assign bus.grant_id_o  = r_grant;

endmodule

// File: tb/tb_mesi_isc_mbus_mem_arb.sv
// Directed bench for mesi_isc_mbus_mem_arb with MEM_LAT=2.
// Inputs are driven and outputs are checked on the falling edge.
module tb_mesi_isc_mbus_mem_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mesi_isc_mbus_mem_arb_if #(.MBUS_CMD_WIDTH(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    mesi_isc_mbus_mem_arb #(
        .MBUS_CMD_WIDTH(3),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_ADDR_WIDTH(4),
        .MEM_LAT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int n, input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        bus_if.mbus_cmd_i[n*3 +: 3]   = cmd;
        bus_if.mbus_addr_i[n*32 +: 32] = addr;
        bus_if.mbus_data_i[n*32 +: 32] = data;
    endtask

    // Follows one transaction and ends on the falling edge of its ACK cycle.
    // When from_idle=0, the call starts in the previous ACK cycle, so one IDLE cycle comes first.
    task automatic xact(input bit from_idle, input logic [3:0] exp_ack, input logic [1:0] exp_gid,
                        input logic [31:0] exp_data, input string tag);
        if (!from_idle) begin
            @(negedge clk);
            check({tag, "_idle_ack"}, 32'(bus_if.mbus_ack_o), 32'd0);
            check({tag, "_idle_busy"}, 32'(bus_if.busy_o), 32'd0);
        end
        repeat (2) begin
            @(negedge clk);
            check({tag, "_acc_ack"}, 32'(bus_if.mbus_ack_o), 32'd0);
            check({tag, "_acc_busy"}, 32'(bus_if.busy_o), 32'd1);
        end
        @(negedge clk);
        check({tag, "_ack"}, 32'(bus_if.mbus_ack_o), 32'(exp_ack));
        check({tag, "_gid"}, 32'(bus_if.grant_id_o), 32'(exp_gid));
        check({tag, "_data"}, bus_if.mbus_data_o, exp_data);
    endtask

    initial begin
        // Test 1: reset held for 2 cycles while every CPU issues RD.
        for (int n = 0; n < 4; n++) drive(n, 3'd2, 32'(n + 8), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_ack", 32'(bus_if.mbus_ack_o), 32'd0);
            check("rst_busy", 32'(bus_if.busy_o), 32'd0);
            check("rst_data", bus_if.mbus_data_o, 32'd0);
            check("rst_gid", 32'(bus_if.grant_id_o), 32'd0);
        end
        rst = 1'b0;

        // Test 3: four simultaneous RDs are served in order 0,1,2,3, with acks 4 cycles apart.
        xact(1'b1, 4'b0001, 2'd0, 32'd0, "rr0");
        drive(0, 3'd0, 32'd0, 32'd0);
        xact(1'b0, 4'b0010, 2'd1, 32'd0, "rr1");
        drive(1, 3'd0, 32'd0, 32'd0);
        xact(1'b0, 4'b0100, 2'd2, 32'd0, "rr2");
        drive(2, 3'd0, 32'd0, 32'd0);
        xact(1'b0, 4'b1000, 2'd3, 32'd0, "rr3");
        drive(3, 3'd0, 32'd0, 32'd0);

        // Test 2: CPU1 WR to 0x5, then CPU2 RD from 0x15 (wraps to index 5).
        drive(1, 3'd1, 32'h5, 32'hDEADBEEF);
        xact(1'b0, 4'b0010, 2'd1, 32'd0, "wr1");
        drive(1, 3'd0, 32'd0, 32'd0);
        drive(2, 3'd2, 32'h15, 32'd0);
        xact(1'b0, 4'b0100, 2'd2, 32'hDEADBEEF, "rd2_wrap");
        drive(2, 3'd0, 32'd0, 32'd0);

        // Test 4: CPU3 is served (a WR, which leaves read data unchanged).
        // Then CPU3 and CPU0 request together, and CPU0 wins.
        drive(3, 3'd1, 32'h7, 32'h11);
        xact(1'b0, 4'b1000, 2'd3, 32'hDEADBEEF, "wr3_hold");
        drive(3, 3'd2, 32'h7, 32'd0);
        drive(0, 3'd2, 32'h5, 32'd0);
        xact(1'b0, 4'b0001, 2'd0, 32'hDEADBEEF, "pair_cpu0");
        drive(0, 3'd0, 32'd0, 32'd0);
        xact(1'b0, 4'b1000, 2'd3, 32'h11, "pair_cpu3");
        drive(3, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("post_idle_busy", 32'(bus_if.busy_o), 32'd0);

        // Test 5: reset arrives during ACCESS of a CPU0 WR, so no ack is issued.
        drive(0, 3'd1, 32'h2, 32'h1234);
        @(negedge clk);
        check("abort_acc_busy", 32'(bus_if.busy_o), 32'd1);
        rst = 1'b1;
        drive(0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        check("abort_rst_busy", 32'(bus_if.busy_o), 32'd0);
        check("abort_rst_ack", 32'(bus_if.mbus_ack_o), 32'd0);
        check("abort_rst_data", bus_if.mbus_data_o, 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_ack", 32'(bus_if.mbus_ack_o), 32'd0);
        end
        drive(0, 3'd2, 32'h2, 32'd0);
        xact(1'b1, 4'b0001, 2'd0, 32'd0, "abort_rd");
        drive(0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);

        // Test 6: unknown command code 3 from CPU2 is ignored.
        drive(2, 3'd3, 32'h4, 32'h55);
        repeat (10) begin
            @(negedge clk);
            check("bcast_busy", 32'(bus_if.busy_o), 32'd0);
            check("bcast_ack", 32'(bus_if.mbus_ack_o), 32'd0);
        end
        drive(2, 3'd0, 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
